// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, FSM/port enums and the error fill pattern for the memory responder.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] ERR_PATTERN = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {INSTR, DATA} port_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, read/write on enable, write-first on the same address.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: arbitrated fetch/data RAM responder with fixed read latency, single outstanding transaction.
// Build with MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH instead of wrapping them.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [WORD_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_resp_valid,
  output logic [WORD_W-1:0] i_resp_data,
  output logic              i_resp_err,
  input  logic              i_resp_ready,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [WORD_W-1:0] d_req_addr,
  input  logic [WORD_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [WORD_W-1:0] d_resp_data,
  output logic              d_resp_err,
  input  logic              d_resp_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAST = 3'(LATENCY - 2);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  state_e state_q, state_d;
  port_e last_q, last_d, sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;
  logic store_q, store_d, err_q, err_d;
  logic idle, gnt_i, gnt_d, acc, oob;
  logic [WORD_W-1:0] addr, ram_q, word;
  assign idle  = state_q == IDLE && !rst;
  assign gnt_i = idle && i_req_valid && (!d_req_valid || last_q == DATA);
  assign gnt_d = idle && d_req_valid && !gnt_i;
  assign acc   = gnt_i || gnt_d;
  assign addr  = gnt_d ? d_req_addr : i_req_addr;
  // Without bounds checking CHECK is 0, so the upper address bits simply wrap.
  assign oob   = CHECK && (addr >= WORD_W'(DEPTH));
  assign i_req_ready = gnt_i;
  assign d_req_ready = gnt_d;
  mem_array #(.DEPTH(DEPTH)) u_ram (
    .clk,
    .en_i   (acc),
    .we_i   (gnt_d && d_req_we && !oob),
    .addr_i (addr[AW-1:0]),
    .wdata_i(d_req_wdata),
    .rdata_o(ram_q)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    store_d = store_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = LATENCY > 1 ? WAIT : RESP;
        cnt_d   = '0;
        sel_d   = gnt_d ? DATA : INSTR;
        last_d  = gnt_d ? DATA : INSTR;
        store_d = gnt_d && d_req_we;
        err_d   = oob;
      end
      WAIT: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == LAST ? RESP : WAIT;
      end
      RESP: state_d = (sel_q == DATA ? d_resp_ready : i_resp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= DATA;
      sel_q   <= INSTR;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end
  assign word         = store_q ? '0 : err_q ? ERR_PATTERN : ram_q;
  assign i_resp_valid = state_q == RESP && sel_q == INSTR;
  assign d_resp_valid = state_q == RESP && sel_q == DATA;
  assign i_resp_data  = i_resp_valid ? word : '0;
  assign d_resp_data  = d_resp_valid ? word : '0;
  assign i_resp_err   = i_resp_valid && err_q;
  assign d_resp_err   = d_resp_valid && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of arbitration, latency, backpressure, reset and address bounds.
module tb_mem_responder;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic i_req_valid = 0, i_req_ready, i_resp_valid, i_resp_err, i_resp_ready = 1;
  logic d_req_valid = 0, d_req_we = 0, d_req_ready, d_resp_valid, d_resp_err, d_resp_ready = 1;
  logic [31:0] i_req_addr = 0, i_resp_data, d_req_addr = 0, d_req_wdata = 0, d_resp_data;
  logic f_i_req_valid = 0, f_i_req_ready, f_i_resp_valid, f_i_resp_err, f_i_resp_ready = 1;
  logic f_d_req_valid = 0, f_d_req_we = 0, f_d_req_ready, f_d_resp_valid, f_d_resp_err, f_d_resp_ready = 1;
  logic [31:0] f_i_req_addr = 0, f_i_resp_data, f_d_req_addr = 0, f_d_req_wdata = 0, f_d_resp_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(4096), .LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err), .i_resp_ready(i_resp_ready),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_resp_err(d_resp_err), .d_resp_ready(d_resp_ready));
  mem_responder #(.DEPTH(4096), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .i_req_valid(f_i_req_valid), .i_req_addr(f_i_req_addr), .i_req_ready(f_i_req_ready),
    .i_resp_valid(f_i_resp_valid), .i_resp_data(f_i_resp_data), .i_resp_err(f_i_resp_err), .i_resp_ready(f_i_resp_ready),
    .d_req_valid(f_d_req_valid), .d_req_we(f_d_req_we), .d_req_addr(f_d_req_addr), .d_req_wdata(f_d_req_wdata),
    .d_req_ready(f_d_req_ready), .d_resp_valid(f_d_resp_valid), .d_resp_data(f_d_resp_data),
    .d_resp_err(f_d_resp_err), .d_resp_ready(f_d_resp_ready));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic dreq(input logic we, input logic [31:0] a, input logic [31:0] w);
    d_req_valid = 1; d_req_we = we; d_req_addr = a; d_req_wdata = w;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] w);
    dreq(1, a, w);
    tick;
    d_req_valid = 0;
    tick;
  endtask
  task automatic test_reset;
    rst = 1; i_req_valid = 1; d_req_valid = 1; f_d_req_valid = 1;
    tick;
    tick;
    #1;
    total++; if ({i_req_ready, d_req_ready, f_d_req_ready} !== 3'b000) begin bad++; $display("FAIL rst_ready got %b want 000", {i_req_ready, d_req_ready, f_d_req_ready}); end
    total++; if ({i_resp_valid, d_resp_valid, i_resp_err, d_resp_err, f_d_resp_valid, f_d_resp_err} !== 6'b0) begin bad++; $display("FAIL rst_valid_err got %b want 000000", {i_resp_valid, d_resp_valid, i_resp_err, d_resp_err, f_d_resp_valid, f_d_resp_err}); end
    total++; if ({i_resp_data, d_resp_data, f_d_resp_data} !== 96'b0) begin bad++; $display("FAIL rst_data got %h %h %h want 0", i_resp_data, d_resp_data, f_d_resp_data); end
    i_req_valid = 0; d_req_valid = 0; f_d_req_valid = 0; rst = 0;
    tick;
  endtask
  task automatic test_store_load;
    dreq(1, 5, 32'h12345678);
    #1;
    total++; if (d_req_ready !== 1'b1) begin bad++; $display("FAIL st_ready got %b want 1", d_req_ready); end
    tick;
    d_req_valid = 0;
    total++; if ({d_resp_valid, d_resp_err} !== 2'b10 || d_resp_data !== 32'h0) begin bad++; $display("FAIL st_ack got v=%b e=%b d=%h want v=1 e=0 d=0", d_resp_valid, d_resp_err, d_resp_data); end
    tick;
    total++; if (d_resp_valid !== 1'b0) begin bad++; $display("FAIL st_done got %b want 0", d_resp_valid); end
    i_req_valid = 1; i_req_addr = 5;
    #1;
    total++; if (i_req_ready !== 1'b1) begin bad++; $display("FAIL ld_ready got %b want 1", i_req_ready); end
    tick;
    i_req_valid = 0;
    total++; if (i_resp_valid !== 1'b1 || i_resp_data !== 32'h12345678) begin bad++; $display("FAIL ld_data got v=%b d=%h want v=1 d=12345678", i_resp_valid, i_resp_data); end
    tick;
  endtask
  task automatic test_contention;
    rst = 1;
    tick;
    rst = 0;
    store(1, 32'hA1A1A1A1);
    store(2, 32'hB2B2B2B2);
    i_req_valid = 1; i_req_addr = 1;
    dreq(0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if ({i_req_ready, d_req_ready} !== (k % 2 == 0 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL arb_grant%0d got %b want %b", k, {i_req_ready, d_req_ready}, (k % 2 == 0 ? 2'b10 : 2'b01)); end
      tick;
      if (k % 2 == 0) begin
        total++; if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0 || i_resp_data !== 32'hA1A1A1A1) begin bad++; $display("FAIL arb_fetch%0d got iv=%b dv=%b d=%h want iv=1 dv=0 d=a1a1a1a1", k, i_resp_valid, d_resp_valid, i_resp_data); end
      end else begin
        total++; if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0 || d_resp_data !== 32'hB2B2B2B2) begin bad++; $display("FAIL arb_load%0d got dv=%b iv=%b d=%h want dv=1 iv=0 d=b2b2b2b2", k, d_resp_valid, i_resp_valid, d_resp_data); end
      end
      tick;
    end
    i_req_valid = 0; d_req_valid = 0;
  endtask
  task automatic test_backpressure;
    d_resp_ready = 0;
    dreq(0, 2, 0);
    tick;
    d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (d_resp_valid !== 1'b1 || d_resp_data !== 32'hB2B2B2B2 || i_req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got v=%b d=%h ir=%b want v=1 d=b2b2b2b2 ir=0", k, d_resp_valid, d_resp_data, i_req_ready); end
      tick;
    end
    i_req_valid = 0;
    d_resp_ready = 1;
    tick;
    i_req_valid = 1;
    #1;
    total++; if (d_resp_valid !== 1'b0 || i_req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got v=%b ir=%b want v=0 ir=1", d_resp_valid, i_req_ready); end
    i_req_valid = 0;
    tick;
  endtask
  task automatic test_bounds;
    store(0, 32'hCAFE0000);
    dreq(0, 32'h1000, 0);
    tick;
    d_req_valid = 0;
    total++; if (d_resp_data !== (CHK ? 32'hDEADBEEF : 32'hCAFE0000) || d_resp_err !== CHK) begin bad++; $display("FAIL oob_load got d=%h e=%b want d=%h e=%b", d_resp_data, d_resp_err, (CHK ? 32'hDEADBEEF : 32'hCAFE0000), CHK); end
    tick;
    i_req_valid = 1; i_req_addr = 32'h1000;
    tick;
    i_req_valid = 0;
    total++; if (i_resp_data !== (CHK ? 32'hDEADBEEF : 32'hCAFE0000) || i_resp_err !== CHK) begin bad++; $display("FAIL oob_fetch got d=%h e=%b want d=%h e=%b", i_resp_data, i_resp_err, (CHK ? 32'hDEADBEEF : 32'hCAFE0000), CHK); end
    tick;
    dreq(1, 32'h1000, 32'h0BADF00D);
    tick;
    d_req_valid = 0;
    total++; if (d_resp_valid !== 1'b1 || d_resp_data !== 32'h0 || d_resp_err !== CHK) begin bad++; $display("FAIL oob_store got v=%b d=%h e=%b want v=1 d=0 e=%b", d_resp_valid, d_resp_data, d_resp_err, CHK); end
    tick;
    dreq(0, 0, 0);
    tick;
    d_req_valid = 0;
    total++; if (d_resp_data !== (CHK ? 32'hCAFE0000 : 32'h0BADF00D) || d_resp_err !== 1'b0) begin bad++; $display("FAIL oob_addr0 got d=%h e=%b want d=%h e=0", d_resp_data, d_resp_err, (CHK ? 32'hCAFE0000 : 32'h0BADF00D)); end
    tick;
  endtask
  task automatic f_access(input logic we, input logic [31:0] w, input logic [31:0] exp);
    f_d_req_valid = 1; f_d_req_we = we; f_d_req_addr = 7; f_d_req_wdata = w;
    #1;
    total++; if (f_d_req_ready !== 1'b1) begin bad++; $display("FAIL l4_ready got %b want 1", f_d_req_ready); end
    tick;
    f_d_req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      total++; if (f_d_resp_valid !== 1'b0) begin bad++; $display("FAIL l4_early%0d got %b want 0", k, f_d_resp_valid); end
      tick;
    end
    total++; if (f_d_resp_valid !== 1'b1 || f_d_resp_data !== exp) begin bad++; $display("FAIL l4_resp got v=%b d=%h want v=1 d=%h", f_d_resp_valid, f_d_resp_data, exp); end
    tick;
  endtask
  task automatic test_latency4;
    f_access(1, 32'h00000077, 32'h0);
    f_access(0, 0, 32'h00000077);
  endtask
  task automatic test_reset_wait;
    f_d_req_valid = 1; f_d_req_we = 0; f_d_req_addr = 7;
    tick;
    f_d_req_valid = 0;
    tick;
    rst = 1;
    tick;
    total++; if ({f_d_req_ready, f_d_resp_valid, f_d_resp_err, f_i_req_ready, f_i_resp_valid, f_i_resp_err} !== 6'b0 || f_d_resp_data !== 32'h0) begin bad++; $display("FAIL rw_outputs got %b d=%h want 000000 d=0", {f_d_req_ready, f_d_resp_valid, f_d_resp_err, f_i_req_ready, f_i_resp_valid, f_i_resp_err}, f_d_resp_data); end
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      total++; if (f_d_resp_valid !== 1'b0) begin bad++; $display("FAIL rw_noresp%0d got %b want 0", k, f_d_resp_valid); end
    end
    f_access(0, 0, 32'h00000077);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_store_load;
    test_contention;
    test_backpressure;
    test_bounds;
    test_latency4;
    test_reset_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory responder serving the CPU's two initiators: the instruction-fetch port and the load/store data port.
- Owns the 4096 x 32b RAM, arbitrates between the two ports and returns read data after a fixed latency.
- All transfers use a valid/ready handshake.
- Replaces direct array indexing inside the core, allowing fetch and load/store to stall.

Parameters:
- DEPTH, 4096: number of 32b words; must be a power of two.
- LATENCY, 1: cycles from request acceptance to response valid; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  fetch request.
- i_req_addr  in  32  fetch word address.
- i_req_ready  out  1  fetch request accepted.
- i_resp_valid  out  1  fetch data valid.
- i_resp_data  out  32  fetch data.
- i_resp_err  out  1  fetch address error.
- i_resp_ready  in  1  CPU takes fetch response.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  32  data word address.
- d_req_wdata  in  32  store data.
- d_req_ready  out  1  data request accepted.
- d_resp_valid  out  1  load data or store acknowledge valid.
- d_resp_data  out  32  load data; 0 for a store.
- d_resp_err  out  1  data address error.
- d_resp_ready  in  1  CPU takes data response.

Behaviour:
- Single outstanding transaction. FSM states: IDLE, WAIT, RESP.
- Reset:
  - state = IDLE, latency counter = 0, last_grant = DATA.
  - All *_ready, *_resp_valid and *_resp_err outputs = 0; resp_data = 0.
  - RAM contents are not reset.
- IDLE:
  - i_req_ready and d_req_ready are combinational grants; at most one is high.
  - If only one port is valid, that port is granted.
  - If both are valid, round-robin: grant the port that is not last_grant. The first contention after reset therefore goes to fetch.
  - Accept = valid & ready at posedge; last_grant updates on accept.
  - Store: RAM is written on the accept edge.
  - Load/fetch: RAM is read on the accept edge, and the word is captured into the response register.
  - Next state: WAIT if LATENCY > 1, else RESP.
- WAIT: count LATENCY-1 cycles, then go to RESP. Both ready outputs are 0.
- RESP:
  - The granted port's resp_valid = 1 and resp_data is held stable.
  - Stay in RESP until that port's resp_ready = 1 at posedge, then return to IDLE.
  - No new request is accepted in the same cycle the response is consumed; the next accept is possible the following cycle.
- Latency: the response is valid exactly LATENCY cycles after the accept edge, e.g. accept at edge N → resp_valid high from edge N+1 when LATENCY = 1.
- Ordering: read-after-write across ports is coherent, because stores complete on the accept edge.
- Address: only bits [log2(DEPTH)-1:0] index the RAM; upper bits are handled per the optional feature.
- Reset mid-operation: any in-flight transaction is dropped with no response; a store already accepted stays written.
- A requester may deassert valid before it is accepted; no state changes.

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - Any address >= DEPTH is flagged. A load or fetch returns 32'hDEADBEEF with resp_err = 1.
  - A store is suppressed, its acknowledge has resp_err = 1, and the RAM is unchanged.
  - Latency and handshake are unchanged.
- Not defined:
  - Upper address bits are ignored, so the address wraps modulo DEPTH.
  - resp_err outputs are tied to 0.

Decomposition:
- Package mem_pkg holds:
  - WORD_W = 32.
  - The state enum {IDLE, WAIT, RESP}.
  - Port-select enum {INSTR, DATA}.
  - ERR_PATTERN = 32'hDEADBEEF.
- One sub-module, mem_array: a single-port synchronous 32b RAM with write enable, DEPTH entries, write-first on the same address.

Test Plan:
- Store then load: data store addr 5 = 32'h12345678 → ack with d_resp_data = 0. Then fetch addr 5 → i_resp_data = 32'h12345678 after LATENCY cycles.
- Contention after reset: both valid in the same cycle, fetch addr 1 and load addr 2 → fetch served first, load second. Repeat with both valid → order alternates.
- Response backpressure: hold d_resp_ready = 0 for 5 cycles → d_resp_valid and d_resp_data stay stable, i_req_ready stays 0. Release → back to IDLE the next cycle.
- LATENCY = 4: accept at edge N → resp_valid first high at edge N+4 and low before that.
- Reset asserted while in WAIT after a load → next cycle all outputs are 0, no response is ever issued, and earlier stored RAM words are still readable.
- Address 4096 (DEPTH = 4096):
  - With MEM_BOUNDS_CHECK_EN: load returns 32'hDEADBEEF with err = 1, and a store leaves addr 0 unchanged.
  - Without the macro: the access aliases to addr 0.
